// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding memory
// requests and buffers returned words in a small prefetch queue feeding decode.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              ir,
  output logic                     ir_valid,
  output logic [31:0]              ir_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int                AW       = $clog2(DEPTH);
  localparam int                CW       = AW + 1;
  localparam logic [31:0]       START_PC = RESET_PC & ~32'h3;
  localparam logic [CW-1:0]     FULL     = CW'(DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   pend_addr;
  logic          pend;
  logic          drop;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   redirect_target;
  logic          push;
  logic          pop;
  logic          issue_wait;

  // A pending request keeps its original address on the bus even after a
  // redirect has moved fpc, so the address is latched when it first waits.
  assign mem_req         = rst_n & ((count < FULL) | pend);
  assign mem_addr        = pend ? pend_addr : fpc;
  assign issue_wait      = mem_req & ~mem_ack;
  assign push            = mem_req & mem_ack & ~drop & ~redirect;
  assign pop             = ~redirect & ~stall & (count != '0);
  assign redirect_target = redirect_pc & ~32'h3;
  assign q_count         = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc       <= START_PC;
      pend_addr <= START_PC;
      pend      <= 1'b0;
      drop      <= 1'b0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      pend <= issue_wait;
      if (issue_wait && !pend)
        pend_addr <= mem_addr;
      if (redirect) begin
        fpc   <= redirect_target;
        drop  <= issue_wait;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (drop && mem_ack)
          drop <= 1'b0;
        if (push) begin
          fpc  <= fpc + 32'd4;
          tail <= tail + AW'(1);
        end
        if (pop)
          head <= head + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail] <= mem_rdata;
      q_pc[tail]   <= mem_addr;
    end
  end

  // Decode output: redirect flushes regardless of stall; an empty queue
  // presents the all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= 32'h0;
      ir_pc    <= 32'h0;
      ir_valid <= 1'b0;
    end else if (redirect) begin
      ir       <= 32'h0;
      ir_pc    <= 32'h0;
      ir_valid <= 1'b0;
    end else if (!stall) begin
      if (count != '0) begin
        ir       <= q_data[head];
        ir_pc    <= q_pc[head];
        ir_valid <= 1'b1;
      end else begin
        ir       <= 32'h0;
        ir_pc    <= 32'h0;
        ir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: streaming, stall/drain, redirect with a slow
// memory, redirect under stall, mid-stream reset and PC wrap-around.
module tb_ifetch_queue;

  logic        clk;
  logic        rst_n;
  logic        mem_req, mem_ack, stall, redirect, ir_valid;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, ir, ir_pc;
  logic [2:0]  q_count;
  logic [1:0]  lat;
  logic [1:0]  waitCnt;

  logic        mem_req2, ir_valid2;
  logic [31:0] mem_addr2, ir2, ir_pc2;
  logic [2:0]  q_count2;

  int checks;
  int passes;

  ifetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .ir(ir),
    .ir_valid(ir_valid), .ir_pc(ir_pc), .q_count(q_count)
  );

  ifetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dutWrap (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(mem_req2), .mem_rdata(mem_addr2 + 32'h1000), .stall(1'b0),
    .redirect(1'b0), .redirect_pc(32'h0), .ir(ir2),
    .ir_valid(ir_valid2), .ir_pc(ir_pc2), .q_count(q_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks after lat wait cycles, returns addr + 0x1000.
  assign mem_ack   = mem_req && (waitCnt >= lat);
  assign mem_rdata = mem_addr + 32'h1000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      waitCnt <= 2'd0;
    else if (mem_req && !mem_ack)
      waitCnt <= waitCnt + 2'd1;
    else
      waitCnt <= 2'd0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected)
      passes++;
    else
      $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    passes      = 0;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    lat         = 2'd0;
    repeat (2) @(negedge clk);

    checkOutput("rst_ir",       ir,              32'h0);
    checkOutput("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
    checkOutput("rst_ir_pc",    ir_pc,           32'h0);
    checkOutput("rst_q_count",  {29'b0, q_count}, 32'h0);
    checkOutput("rst_mem_req",  {31'b0, mem_req}, 32'h0);
    checkOutput("rst_mem_addr", mem_addr,        32'h0);
    checkOutput("rst_wrap_addr", mem_addr2,      32'hFFFF_FFF8);

    rst_n = 1'b1;
    #1;
    checkOutput("first_req",  {31'b0, mem_req}, 32'h1);
    checkOutput("first_addr", mem_addr,          32'h0);

    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("fill_valid", {31'b0, ir_valid}, 32'h0);
    checkOutput("fill_count", {29'b0, q_count}, 32'h1);
    checkOutput("fill_addr",  mem_addr,         32'h4);
    checkOutput("wrap_addr1", mem_addr2,        32'hFFFF_FFFC);

    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr2", mem_addr2, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stream_ir",    ir,                 32'h1000 + 32'(4 * i));
      checkOutput("stream_pc",    ir_pc,              32'(4 * i));
      checkOutput("stream_valid", {31'b0, ir_valid},  32'h1);
      checkOutput("wrap_pc",      ir_pc2,             32'hFFFF_FFF8 + 32'(4 * i));
      if (i < 2) applyStimulus(1'b0, 1'b0, 32'h0);
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("stall_hold_ir", ir, 32'h1008);
    end
    checkOutput("stall_count",   {29'b0, q_count}, 32'h4);
    checkOutput("stall_req_low", {31'b0, mem_req}, 32'h0);
    checkOutput("stall_hold_pc", ir_pc,            32'h8);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("drain_pc",    ir_pc,             32'hC + 32'(4 * i));
      checkOutput("drain_ir",    ir,                32'h100C + 32'(4 * i));
      checkOutput("drain_valid", {31'b0, ir_valid}, 32'h1);
    end

    rst_n = 1'b0;
    lat   = 2'd2;
    #1;
    checkOutput("midrst_ir",    ir,                32'h0);
    checkOutput("midrst_valid", {31'b0, ir_valid}, 32'h0);
    checkOutput("midrst_pc",    ir_pc,             32'h0);
    checkOutput("midrst_count", {29'b0, q_count},  32'h0);
    checkOutput("midrst_req",   {31'b0, mem_req},  32'h0);
    checkOutput("midrst_addr",  mem_addr,          32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("restart_req",  {31'b0, mem_req}, 32'h1);
    checkOutput("restart_addr", mem_addr,         32'h0);

    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("slow_hold_addr", mem_addr,         32'h0);
    checkOutput("slow_hold_req",  {31'b0, mem_req}, 32'h1);

    applyStimulus(1'b0, 1'b1, 32'h0000_0203);
    checkOutput("redir_valid",   {31'b0, ir_valid}, 32'h0);
    checkOutput("redir_old_addr", mem_addr,         32'h0);
    checkOutput("redir_req",     {31'b0, mem_req},  32'h1);

    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("drop_new_addr", mem_addr,         32'h200);
    checkOutput("drop_count",    {29'b0, q_count}, 32'h0);
    checkOutput("drop_valid",    {31'b0, ir_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("tgt_addr",      mem_addr,          32'h200);
    checkOutput("tgt_valid1",    {31'b0, ir_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("tgt_valid2",    {31'b0, ir_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("tgt_count",     {29'b0, q_count},  32'h1);
    checkOutput("tgt_valid3",    {31'b0, ir_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("tgt_ir",        ir,                32'h1200);
    checkOutput("tgt_pc",        ir_pc,             32'h200);
    checkOutput("tgt_ir_valid",  {31'b0, ir_valid}, 32'h1);

    applyStimulus(1'b1, 1'b1, 32'h0000_0300);
    checkOutput("rs_valid", {31'b0, ir_valid}, 32'h0);
    checkOutput("rs_ir",    ir,                32'h0);
    checkOutput("rs_pc",    ir_pc,             32'h0);
    checkOutput("rs_count", {29'b0, q_count},  32'h0);
    checkOutput("rs_addr",  mem_addr,          32'h204);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rs_new_addr", mem_addr,          32'h300);
    checkOutput("rs_valid2",   {31'b0, ir_valid}, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
